// File: rtl/stk_ptr_alloc_if.sv
// stk_ptr_alloc_if: allocate/free handshake and status bundle of the stack pointer allocator
interface stk_ptr_alloc_if #(
   parameter int PTR_W = 8,
   parameter int CNT_W = 9
);
   logic             i_alloc_req;
   logic             o_alloc_vld;
   logic [PTR_W-1:0] o_alloc_ptr;
   logic             i_free_vld;
   logic [PTR_W-1:0] i_free_ptr;
   logic             o_busy;
   logic             o_empty;
   logic [CNT_W-1:0] o_cnt;
   logic             o_err;
   modport master (
      output i_alloc_req, i_free_vld, i_free_ptr,
      input  o_alloc_vld, o_alloc_ptr, o_busy, o_empty, o_cnt, o_err
   );
   modport slave (
      input  i_alloc_req, i_free_vld, i_free_ptr,
      output o_alloc_vld, o_alloc_ptr, o_busy, o_empty, o_cnt, o_err
   );
endinterface

// File: rtl/stk_ptr_alloc.sv
// stk_ptr_alloc: FIFO free list of stack-entry pointers; STK_PTR_ALLOC_DOUBLE_FREE_CHECK_EN adds an allocated bitmap
module stk_ptr_alloc #(
   parameter int PTR_W = 8,
   parameter int N     = 256,
   parameter int CNT_W = $clog2(N + 1)
) (
   input logic            clk,
   input logic            arst,
   stk_ptr_alloc_if.slave bus
);
   localparam int IX_W = $clog2(N);
   localparam logic [0:0] INIT  = 1'b0;
   localparam logic [0:0] READY = 1'b1;

   logic [0:0]       state;
   logic [PTR_W-1:0] slot [N];
   logic [IX_W-1:0]  rd_ix, wr_ix;
   logic [CNT_W-1:0] cnt;
   logic             err, ready, alloc_fire, free_ok, dbl_ok;
   logic [PTR_W-1:0] alloc_ptr;

   function automatic logic [IX_W-1:0] nxt(input logic [IX_W-1:0] ix);
      return (ix == IX_W'(N - 1)) ? '0 : ix + 1'b1;
   endfunction

   assign ready      = state == READY;
   assign alloc_ptr  = slot[rd_ix];
   assign alloc_fire = ready & bus.i_alloc_req & (cnt != '0);
   assign free_ok    = ready & bus.i_free_vld & (32'(bus.i_free_ptr) < N)
                     & ~((cnt == CNT_W'(N)) & ~alloc_fire) & dbl_ok;

`ifdef STK_PTR_ALLOC_DOUBLE_FREE_CHECK_EN
   logic [N-1:0] alloc_map;
   assign dbl_ok = alloc_map[bus.i_free_ptr];

   // track outstanding pointers; a free is judged against the map before this cycle's grant
   always_ff @(posedge clk or posedge arst)
      if (arst) alloc_map <= '0;
      else if (!ready) alloc_map <= '0;
      else begin
         if (alloc_fire) alloc_map[alloc_ptr] <= 1'b1;
         if (free_ok) alloc_map[bus.i_free_ptr] <= 1'b0;
      end
`else
   assign dbl_ok = 1'b1;
`endif

   // state, indices, count and sticky error; INIT reuses wr_ix as the fill counter
   always_ff @(posedge clk or posedge arst)
      if (arst) begin
         state <= INIT;
         rd_ix <= '0;
         wr_ix <= '0;
         cnt   <= '0;
         err   <= 1'b0;
      end else begin
         err <= err | (bus.i_free_vld & ~free_ok);
         if (!ready) begin
            wr_ix <= nxt(wr_ix);
            cnt   <= cnt + 1'b1;
            state <= (wr_ix == IX_W'(N - 1)) ? READY : INIT;
         end else begin
            if (alloc_fire) rd_ix <= nxt(rd_ix);
            if (free_ok) wr_ix <= nxt(wr_ix);
            cnt <= cnt + CNT_W'(free_ok) - CNT_W'(alloc_fire);
         end
      end

   // slot storage: identity fill during INIT, accepted returns once READY
   always_ff @(posedge clk)
      if (!ready || free_ok) slot[wr_ix] <= ready ? bus.i_free_ptr : PTR_W'(wr_ix);

   assign bus.o_alloc_vld = ready & (cnt != '0);
   assign bus.o_alloc_ptr = alloc_ptr;
   assign bus.o_busy      = ~ready;
   assign bus.o_empty     = ready & (cnt == '0);
   assign bus.o_cnt       = cnt;
   assign bus.o_err       = err;
endmodule
